// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the four-channel mux scan sequencer.
// Contents:
//   NCH, SEL_W   - channel count and select width
//   scan_state_e - sequencer states (IDLE, SETTLE, PUBLISH)
//   dwell_cnt_w  - dwell counter width for a given DWELL, never below 1
//   frame_parity - even-parity helper over a frame
package mux_scan_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PUBLISH = 2'd2
  } scan_state_e;

  function automatic int dwell_cnt_w(input int dwell);
    int w;
    w = $clog2(dwell);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic frame_parity(input logic [NCH-1:0] f);
    return ^f;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bus between a scan requester and mux_scan_ctrl.
// Signals: start/cont/abort (requests), y (mux output), s1/s0 (mux selects),
// busy, frame, frame_valid, and frame_par when MUX_SCAN_PARITY_EN is defined.
// Modports: master = requester side, slave = the sequencer.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic           start;
  logic           cont;
  logic           abort;
  logic           y;
  logic           s1;
  logic           s0;
  logic           busy;
  logic [NCH-1:0] frame;
  logic           frame_valid;
`ifdef MUX_SCAN_PARITY_EN
  logic           frame_par;

  modport master (output start, cont, abort,
                  input  y, s1, s0, busy, frame, frame_valid, frame_par);
  modport slave  (input  start, cont, abort, y,
                  output s1, s0, busy, frame, frame_valid, frame_par);
`else
  modport master (output start, cont, abort,
                  input  y, s1, s0, busy, frame, frame_valid);
  modport slave  (input  start, cont, abort, y,
                  output s1, s0, busy, frame, frame_valid);
`endif

endinterface

// File: rtl/mux_4x1.sv
// Plain 4:1 mux that the sequencer scans.
// Ports: i0..i3 data inputs, s1/s0 select (s1 = MSB), y selected output.
module mux_4x1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic y
);

  // Route the selected input to y.
  always_comb begin
    y = 1'b0;
    case ({s1, s0})
      2'b00:   y = i0;
      2'b01:   y = i1;
      2'b10:   y = i2;
      2'b11:   y = i3;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_scan_ctrl_timer.sv
// scan_dwell_timer: dwell counter for one selected channel.
// Ports: clk, rst_n (async active-low), clr (highest priority, forces 0),
// en (count up), tc (count has reached DWELL-1).
module scan_dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW   = dwell_cnt_w(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Kept independent of en so the controller's next-state logic has no loop.
  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the selects of a downstream mux_4x1 through channels
// 0..3, samples y after DWELL cycles per channel and publishes a 4-bit frame.
// Ports: clk, rst_n (async active-low), bus (mux_scan_ctrl_if.slave):
//   start/cont/abort in, y in, s1/s0 out, busy out, frame out, frame_valid out.
// Optional: MUX_SCAN_PARITY_EN adds bus.frame_par (XOR of frame bits).
// All outputs come straight from flops.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_scan_ctrl_if.slave        bus
);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             frame_valid_q, frame_valid_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   frame_q, frame_d;
`ifdef MUX_SCAN_PARITY_EN
  logic             frame_par_q, frame_par_d;
`endif
  logic             tmr_clr_s;
  logic             tmr_en_s;
  logic             tmr_tc_s;

  scan_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr_s),
    .en    (tmr_en_s),
    .tc    (tmr_tc_s)
  );

  // Next state and next register values; abort overrides every state.
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    sel_d         = sel_q;
    busy_d        = busy_q;
    frame_valid_d = 1'b0;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    tmr_clr_s     = 1'b1;
    tmr_en_s      = 1'b0;
    if (bus.abort) begin
      state_d  = IDLE;
      ch_d     = {SEL_W{1'b0}};
      sel_d    = {SEL_W{1'b0}};
      busy_d   = 1'b0;
      shadow_d = {NCH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          ch_d  = {SEL_W{1'b0}};
          sel_d = {SEL_W{1'b0}};
          if (bus.start) begin
            state_d = SETTLE;
            busy_d  = 1'b1;
          end else begin
            busy_d  = 1'b0;
          end
        end
        SETTLE: begin
          tmr_en_s  = 1'b1;
          tmr_clr_s = 1'b0;
          if (tmr_tc_s) begin
            tmr_clr_s      = 1'b1;
            shadow_d[ch_q] = bus.y;
            if (ch_q == SEL_W'(NCH - 1)) begin
              // Last sample lands in the frame on the same edge it is taken.
              state_d       = PUBLISH;
              frame_d       = shadow_d;
              frame_valid_d = 1'b1;
              sel_d         = {SEL_W{1'b1}};
            end else begin
              ch_d  = ch_q + SEL_W'(1);
              sel_d = ch_q + SEL_W'(1);
            end
          end else begin
            tmr_clr_s = 1'b0;
          end
        end
        PUBLISH: begin
          ch_d  = {SEL_W{1'b0}};
          sel_d = {SEL_W{1'b0}};
          if (bus.cont) begin
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          ch_d    = {SEL_W{1'b0}};
          sel_d   = {SEL_W{1'b0}};
          busy_d  = 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // Parity follows frame and only changes when a frame is published.
  always_comb begin
    if (frame_valid_d) begin
      frame_par_d = frame_parity(frame_d);
    end else begin
      frame_par_d = frame_par_q;
    end
  end

  // Parity register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_par_q <= 1'b0;
    end else begin
      frame_par_q <= frame_par_d;
    end
  end

  assign bus.frame_par = frame_par_q;
`endif

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ch_q          <= {SEL_W{1'b0}};
      sel_q         <= {SEL_W{1'b0}};
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      shadow_q      <= {NCH{1'b0}};
      frame_q       <= {NCH{1'b0}};
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      sel_q         <= sel_d;
      busy_q        <= busy_d;
      frame_valid_q <= frame_valid_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
    end
  end

  assign bus.s1          = sel_q[1];
  assign bus.s0          = sel_q[0];
  assign bus.busy        = busy_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Integration bench: two mux_scan_ctrl instances (DWELL=2 and DWELL=1), each
// scanning a real mux_4x1. Expected selects, frames and pulses come from the
// timing rules: channel n is selected during cycles [n*D,(n+1)*D) after start
// acceptance and sampled in cycle (n+1)*D-1; frame_valid lands in cycle 4*D.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] in_a, in_b;
  logic [3:0] model_frame_a;
  logic       y_a, y_b;

  mux_scan_ctrl_if bus_a();
  mux_scan_ctrl_if bus_b();

  mux_scan_ctrl #(.DWELL(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_scan_ctrl #(.DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  mux_4x1 mux_a (.i0(in_a[0]), .i1(in_a[1]), .i2(in_a[2]), .i3(in_a[3]),
                 .s1(bus_a.s1), .s0(bus_a.s0), .y(y_a));
  mux_4x1 mux_b (.i0(in_b[0]), .i1(in_b[1]), .i2(in_b[2]), .i3(in_b[3]),
                 .s1(bus_b.s1), .s0(bus_b.s0), .y(y_b));

  assign bus_a.y = y_a;
  assign bus_b.y = y_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_a(input string tag, input logic [3:0] exp_frame);
    checks++;
    if ({bus_a.busy, bus_a.frame_valid, bus_a.s1, bus_a.s0} !== 4'b0000) begin
      errors++;
      $display("FAIL %s idle_a busy/fv/sel got %b want 0000", tag,
               {bus_a.busy, bus_a.frame_valid, bus_a.s1, bus_a.s0});
    end
    checks++;
    if (bus_a.frame !== exp_frame) begin
      errors++;
      $display("FAIL %s idle_a frame got %b want %b", tag, bus_a.frame, exp_frame);
    end
  endtask

  // One DWELL=2 scan on dut_a. rand_ins re-randomises the mux inputs every
  // cycle; abort_at/start_at (-1 = never) inject abort/start in that cycle.
  task automatic scan_a(input logic [3:0] ins, input bit rand_ins,
                        input int abort_at, input int start_at, input string tag);
    int         d;
    logic [1:0] exp_sel;
    logic [3:0] samp;
    bit         aborted;
    d       = 2;
    samp    = 4'b0000;
    aborted = 1'b0;
    in_a    = ins;
    bus_a.cont  = 1'b0;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int k = 0; k <= 4 * d; k++) begin
      if (rand_ins) in_a = 4'($urandom_range(0, 15));
      exp_sel = (k < 4 * d) ? 2'(k / d) : 2'd3;
      checks++;
      if ({bus_a.s1, bus_a.s0} !== exp_sel) begin
        errors++;
        $display("FAIL %s sel k=%0d got %b want %b", tag, k, {bus_a.s1, bus_a.s0}, exp_sel);
      end
      checks++;
      if (bus_a.busy !== 1'b1 || bus_a.frame_valid !== (k == 4 * d)) begin
        errors++;
        $display("FAIL %s busy/fv k=%0d got %b%b want 1%b", tag, k,
                 bus_a.busy, bus_a.frame_valid, (k == 4 * d));
      end
      if (k == 4 * d) begin
        checks++;
        if (bus_a.frame !== samp) begin
          errors++;
          $display("FAIL %s frame got %b want %b", tag, bus_a.frame, samp);
        end
`ifdef MUX_SCAN_PARITY_EN
        checks++;
        if (bus_a.frame_par !== ^samp) begin
          errors++;
          $display("FAIL %s frame_par got %b want %b", tag, bus_a.frame_par, ^samp);
        end
`endif
      end
      if (k < 4 * d && (k % d) == d - 1) samp[k / d] = in_a[k / d];
      if (k == start_at) bus_a.start = 1'b1;
      if (k == abort_at) begin
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        bus_a.start = 1'b0;
        check_idle_a({tag, "_abort"}, model_frame_a);
        aborted = 1'b1;
        break;
      end
      tick();
      bus_a.start = 1'b0;
    end
    if (!aborted) model_frame_a = samp;
    for (int j = 0; j < 3; j++) begin
      if (!aborted || j > 0) check_idle_a({tag, "_after"}, model_frame_a);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.cont = 1'b0; bus_a.abort = 1'b0;
    bus_b.start = 1'b0; bus_b.cont = 1'b0; bus_b.abort = 1'b0;
    in_a = 4'b0000; in_b = 4'b0000;
    model_frame_a = 4'b0000;
    #12;
    check_idle_a("reset_a", 4'b0000);
    checks++;
    if ({bus_b.busy, bus_b.frame_valid, bus_b.s1, bus_b.s0, bus_b.frame} !== 8'h00) begin
      errors++;
      $display("FAIL reset_b outputs got %b want 00000000",
               {bus_b.busy, bus_b.frame_valid, bus_b.s1, bus_b.s0, bus_b.frame});
    end
`ifdef MUX_SCAN_PARITY_EN
    checks++;
    if (bus_a.frame_par !== 1'b0) begin
      errors++;
      $display("FAIL reset frame_par got %b want 0", bus_a.frame_par);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_a("reset_release", 4'b0000);
  endtask

  task automatic test_single();
    scan_a(4'b1010, 1'b0, -1, -1, "single");
  endtask

  task automatic test_back_to_back();
    scan_a(4'b0110, 1'b0, -1, -1, "b2b_0");
    scan_a(4'b1001, 1'b0, -1, -1, "b2b_1");
  endtask

  task automatic test_abort();
    scan_a(4'b1010, 1'b0, -1, -1, "abort_prior");
    scan_a(4'b0101, 1'b0, 2, -1, "abort_ch1");
  endtask

  task automatic test_start_busy();
    scan_a(4'b1100, 1'b0, -1, 3, "start_busy_mid");
    scan_a(4'b0011, 1'b0, -1, 8, "start_busy_pub");
  endtask

  task automatic test_start_abort();
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check_idle_a("start_abort", model_frame_a);
      tick();
    end
  endtask

  // Continuous DWELL=1 scan: two frames, cont dropped mid second frame.
  task automatic run_cont_b(input logic [3:0] f0, input logic [3:0] f1, input string tag);
    int         p;
    logic [1:0] es;
    in_b = f0;
    bus_b.cont  = 1'b1;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      p = k % 5;
      if (k == 4) in_b = f1;
      if (k == 6) bus_b.cont = 1'b0;
      es = (p < 4) ? 2'(p) : 2'd3;
      checks++;
      if ({bus_b.s1, bus_b.s0} !== es || bus_b.busy !== 1'b1 || bus_b.frame_valid !== (p == 4)) begin
        errors++;
        $display("FAIL %s k=%0d sel/busy/fv got %b%b%b%b want %b1%b", tag, k,
                 bus_b.s1, bus_b.s0, bus_b.busy, bus_b.frame_valid, es, (p == 4));
      end
      if (p == 4) begin
        checks++;
        if (bus_b.frame !== ((k == 4) ? f0 : f1)) begin
          errors++;
          $display("FAIL %s frame k=%0d got %b want %b", tag, k, bus_b.frame, (k == 4) ? f0 : f1);
        end
      end
      tick();
    end
    checks++;
    if ({bus_b.busy, bus_b.frame_valid, bus_b.s1, bus_b.s0} !== 4'b0000 || bus_b.frame !== f1) begin
      errors++;
      $display("FAIL %s end got %b frame %b want 0000 frame %b", tag,
               {bus_b.busy, bus_b.frame_valid, bus_b.s1, bus_b.s0}, bus_b.frame, f1);
    end
    tick();
  endtask

  task automatic test_continuous();
    run_cont_b(4'b1010, 4'b0011, "cont_fixed");
    run_cont_b(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "cont_rand");
  endtask

  task automatic test_random();
    int ab;
    for (int i = 0; i < 8; i++) begin
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      scan_a(4'($urandom_range(0, 15)), 1'b1, ab, -1, "random");
    end
  endtask

  task automatic test_parity();
    scan_a(4'b0111, 1'b0, -1, -1, "parity");
  endtask

  task automatic test_reset_midscan();
    in_a = 4'b1111;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_a("reset_mid", 4'b0000);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check_idle_a("reset_mid_after", 4'b0000);
    end
    model_frame_a = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_start_busy();
    test_start_abort();
    test_continuous();
    test_random();
    test_parity();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
